np_flash_arb: RTL and testbench
===============================

Name: np_flash_arb

Overview:
- Two-port arbiter sharing the single SPI-flash memory interface (valid/ready, 24-bit byte address, 32-bit read data) in the np_top SoC.
- Port 0 is the CPU instruction/data fetch path; port 1 is a bulk loader/DMA path.
- Round-robin arbitration; port 1 can lock the bus for bounded bursts.
- Watchdog aborts a hung flash transaction, returns a poison word and flags an error.

Parameters:
ADDR_W, 24, flash byte-address width
DATA_W, 32, read data width
MAX_BURST, 8, max consecutive locked grants to port 1 while port 0 is waiting (1..255)
TIMEOUT, 1024, cycles in ISSUE without mem_ready before abort (>=2)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous, active-low reset
req0_valid  in  1  port 0 request; held high until req0_ready
req0_addr  in  ADDR_W  port 0 address
req0_ready  out  1  one-cycle completion pulse to port 0
req1_valid  in  1  port 1 request; held high until req1_ready
req1_addr  in  ADDR_W  port 1 address
req1_lock  in  1  port 1 burst-lock request
req1_ready  out  1  one-cycle completion pulse to port 1
rsp_rdata  out  DATA_W  read data, valid while reqX_ready high
mem_valid  out  1  request to flash interface
mem_addr  out  ADDR_W  registered address to flash interface
mem_ready  in  1  flash interface completion
mem_rdata  in  DATA_W  flash read data, valid with mem_ready
owner  out  1  port that owns the current or last transaction
busy  out  1  high in ISSUE and RESP
timeout_err  out  1  sticky abort flag
err_clr  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (RST low, asynchronous) forces state IDLE.
  - Reset values: mem_valid=0, mem_addr=0, req0_ready=0, req1_ready=0, rsp_rdata=0, owner=0, busy=0, timeout_err=0.
  - Internal state: last_grant=1, so port 0 wins the first tie; burst_cnt=0; wd_cnt=0.
- Reset mid-transaction drops mem_valid immediately. No ready pulse is issued for the aborted request.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Sample req0_valid/req1_valid each cycle.
  - Single requester: grant it.
  - Both requesting: grant port 1 if req1_lock=1, last_grant=1 and burst_cnt<MAX_BURST; otherwise grant the port not equal to last_grant.
  - On grant: latch the address into mem_addr, set owner and last_grant, go to ISSUE.
- ISSUE:
  - mem_valid=1, mem_addr stable, wd_cnt increments each cycle.
  - On mem_ready: register mem_rdata into rsp_rdata and go to RESP. mem_valid drops on the next cycle.
  - On wd_cnt==TIMEOUT-1 without mem_ready: rsp_rdata={DATA_W{1'b1}}, set timeout_err, go to RESP.
  - mem_ready arriving in the timeout cycle has priority, i.e. real data, no error.
- RESP:
  - Exactly one cycle; reqX_ready=1 for X=owner; mem_valid=0.
  - Next state is always IDLE, so requester valid dropped after the ready edge is never resampled.
- Latency: grant edge to mem_valid high is 1 cycle. mem_ready edge to reqX_ready high is 1 cycle. Minimum request-to-ready is 3 cycles with zero-wait flash.
- Back-to-back: a requester holding valid continuously after its ready pulse re-enters arbitration in IDLE. No bubble beyond the IDLE cycle.
- burst_cnt:
  - Increments (saturating at MAX_BURST) on each port-1 grant made while req1_lock=1 and req0_valid=1.
  - Cleared on any port-0 grant, or whenever req1_lock=0 in IDLE.
  - Port 0 therefore waits at most MAX_BURST port-1 transactions.
- mem_ready outside ISSUE is ignored.
- timeout_err:
  - Cleared by err_clr in the cycle after err_clr is sampled high.
  - Set has priority over clear in the same cycle.
- busy=1 in ISSUE and RESP; owner holds its value in IDLE.

Test Plan:
- Single port 0 read, addr 0x100000, flash returns 0xDEADBEEF after 4 wait cycles -> mem_addr=0x100000, req0_ready pulses once, 1 cycle after mem_ready, with rsp_rdata=0xDEADBEEF; req1_ready stays 0.
- Both valid from reset, no lock, each re-requests immediately, 6 transactions -> grant order 0,1,0,1,0,1; owner toggles.
- Port 1 lock, both continuously valid, MAX_BURST=8 -> after the first port-0 grant, exactly 8 port-1 grants, then one port-0 grant; the pattern repeats.
- mem_ready never asserted, TIMEOUT=1024 -> mem_valid high exactly 1024 cycles, reqX_ready pulses with rsp_rdata=0xFFFFFFFF, timeout_err=1; err_clr pulse -> timeout_err=0 next cycle.
- mem_ready in the final watchdog cycle -> real data returned, timeout_err remains 0.
- RST low during ISSUE -> mem_valid=0 asynchronously, no ready pulse; after release with both valid, port 0 granted first.

Source files
------------

// File: rtl/np_flash_arb.sv
// Two-port round-robin arbiter in front of the single SPI-flash read interface.
// Port 1 may lock the bus for bounded bursts; a watchdog aborts hung reads with a poison word.
module np_flash_arb #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_lock,
    output logic              req1_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam int BC_W = 8;
    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_BURST);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic [BC_W-1:0]   burst_cnt;
    logic [WD_W-1:0]   wd_cnt;

    logic              gnt_any;
    logic              gnt_port;
    logic              timeout_hit;

    function automatic logic [BC_W-1:0] sat_inc(input logic [BC_W-1:0] v);
        if (v >= BURST_MAX)
            return BURST_MAX;
        else
            return v + BC_W'(1);
    endfunction

    // Arbitration: the lock only extends a port-1 run, it never preempts a port-0 turn.
    always_comb begin
        gnt_any  = req0_valid | req1_valid;
        gnt_port = 1'b0;
        if (req0_valid && req1_valid) begin
            if (req1_lock && last_grant && (burst_cnt < BURST_MAX))
                gnt_port = 1'b1;
            else
                gnt_port = ~last_grant;
        end else begin
            gnt_port = req1_valid;
        end
    end

    // Real data arriving in the last watchdog cycle wins over the abort.
    assign timeout_hit = (state == ISSUE) && !mem_ready && (wd_cnt == WD_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_any) state_nxt = ISSUE;
            ISSUE:   if (mem_ready || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_addr   <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (state == IDLE && gnt_any) begin
            mem_addr   <= gnt_port ? req1_addr : req0_addr;
            owner      <= gnt_port;
            last_grant <= gnt_port;
        end
    end

    // Burst counter only tracks port-1 grants that actually made port 0 wait.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (gnt_any && !gnt_port)
                burst_cnt <= '0;
            else if (!req1_lock)
                burst_cnt <= '0;
            else if (gnt_any && gnt_port && req0_valid)
                burst_cnt <= sat_inc(burst_cnt);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            wd_cnt <= '0;
        else if (state == ISSUE)
            wd_cnt <= wd_cnt + WD_W'(1);
        else
            wd_cnt <= '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rsp_rdata <= '0;
        end else if (state == ISSUE) begin
            if (mem_ready)
                rsp_rdata <= mem_rdata;
            else if (timeout_hit)
                rsp_rdata <= '1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            timeout_err <= 1'b0;
        else if (timeout_hit)
            timeout_err <= 1'b1;
        else if (err_clr)
            timeout_err <= 1'b0;
    end

    // Handshake outputs decode the state register, so reset drops them at once.
    assign mem_valid  = (state == ISSUE);
    assign busy       = (state != IDLE);
    assign req0_ready = (state == RESP) && !owner;
    assign req1_ready = (state == RESP) && owner;

endmodule

// File: tb/tb_np_flash_arb.sv
// Directed bench for np_flash_arb: single read, round-robin, burst lock, watchdog, async reset.
module tb_np_flash_arb;

    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 8;
    localparam int TIMEOUT   = 1024;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic              req1_lock = 1'b0;
    logic              req1_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              owner;
    logic              busy;
    logic              timeout_err;
    logic              err_clr = 1'b0;

    always #5 CLK = ~CLK;

    np_flash_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_lock(req1_lock),
        .req1_ready(req1_ready), .rsp_rdata(rsp_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash model: answers after flash_wait idle cycles of mem_valid.
    logic              flash_en = 1'b1;
    int                flash_wait = 0;
    logic [DATA_W-1:0] flash_data = '0;
    logic              data_mode = 1'b0;
    int                wcnt = 0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge CLK);
            #1;
            mem_ready = 1'b0;
            if (mem_valid && flash_en) begin
                if (wcnt == flash_wait) begin
                    mem_ready = 1'b1;
                    mem_rdata = data_mode ? {8'h00, mem_addr} : flash_data;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    int          cyc = 0;
    int          mv_run = 0;
    int          mv_len = 0;
    int          mr_cyc = -1;
    int          rdy_cyc = -1;
    int          gq[$];
    logic [31:0] dq[$];

    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (mem_valid) mv_run++;
        else if (mv_run != 0) begin
            mv_len = mv_run;
            mv_run = 0;
        end
        if (mem_ready) mr_cyc = cyc;
        if (req0_ready || req1_ready) begin
            gq.push_back(req1_ready ? 1 : 0);
            dq.push_back(rsp_rdata);
            rdy_cyc = cyc;
        end
    endtask

    task automatic wait_grants(input string tag, input int n, input int bound);
        int k;
        k = 0;
        while (gq.size() < n && k < bound) begin
            tick();
            k++;
        end
        chk(tag, 64'(gq.size() >= n), 64'd1);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        gq.delete();
        dq.delete();
        mv_run = 0;
        mv_len = 0;
        RST = 1'b1;
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        chk("rst_ready1", 64'(req1_ready), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_terr", 64'(timeout_err), 64'd0);

        // Single port-0 read with 4 wait cycles
        flash_wait = 4;
        flash_data = 32'hDEADBEEF;
        req0_addr  = 24'h100000;
        req0_valid = 1'b1;
        do_reset();
        wait_grants("t1_wait", 1, 50);
        req0_valid = 1'b0;
        chk("t1_port", 64'(gq.size() > 0 ? gq[0] : 9), 64'd0);
        chk("t1_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        chk("t1_addr", 64'(mem_addr), 64'h100000);
        chk("t1_latency", 64'(rdy_cyc - mr_cyc), 64'd1);
        chk("t1_mv_len", 64'(mv_len), 64'd5);
        chk("t1_busy", 64'(busy), 64'd1);
        repeat (10) tick();
        chk("t1_one_pulse", 64'(gq.size()), 64'd1);

        // Round-robin, no lock, both continuously valid
        flash_wait = 0;
        data_mode  = 1'b1;
        req0_addr  = 24'h000A00;
        req1_addr  = 24'h000B11;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_lock  = 1'b0;
        do_reset();
        wait_grants("rr_wait", 6, 100);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_owner_last", 64'(owner), 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_port%0d", i), 64'(gq.size() > i ? gq[i] : 9), 64'(i % 2));
            chk($sformatf("rr_data%0d", i), 64'(dq.size() > i ? dq[i] : 32'h0),
                (i % 2) ? 64'h000B11 : 64'h000A00);
        end
        repeat (4) tick();

        // Port-1 burst lock: from reset 8 port-1 grants, then port 0, repeating
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_lock  = 1'b1;
        do_reset();
        wait_grants("lk_wait", 18, 200);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req1_lock  = 1'b0;
        for (int i = 0; i < 18; i++)
            chk($sformatf("lk_port%0d", i), 64'(gq.size() > i ? gq[i] : 9),
                (i == 8 || i == 17) ? 64'd0 : 64'd1);
        repeat (4) tick();

        // Watchdog abort, then err_clr
        data_mode  = 1'b0;
        flash_en   = 1'b0;
        req0_addr  = 24'h000040;
        req0_valid = 1'b1;
        do_reset();
        wait_grants("to_wait", 1, TIMEOUT + 50);
        req0_valid = 1'b0;
        chk("to_mv_len", 64'(mv_len), 64'(TIMEOUT));
        chk("to_rdata", 64'(rsp_rdata), 64'hFFFFFFFF);
        chk("to_err_set", 64'(timeout_err), 64'd1);
        tick();
        chk("to_err_sticky", 64'(timeout_err), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_err_clr", 64'(timeout_err), 64'd0);

        // mem_ready in the final watchdog cycle
        flash_en   = 1'b1;
        flash_wait = TIMEOUT - 1;
        flash_data = 32'h12345678;
        req1_addr  = 24'h00C000;
        req1_valid = 1'b1;
        do_reset();
        wait_grants("lc_wait", 1, TIMEOUT + 50);
        req1_valid = 1'b0;
        chk("lc_port", 64'(gq.size() > 0 ? gq[0] : 9), 64'd1);
        chk("lc_mv_len", 64'(mv_len), 64'(TIMEOUT));
        chk("lc_rdata", 64'(rsp_rdata), 64'h12345678);
        chk("lc_no_err", 64'(timeout_err), 64'd0);
        repeat (3) tick();

        // Asynchronous reset during ISSUE
        flash_en   = 1'b0;
        flash_wait = 0;
        req0_addr  = 24'h000123;
        req0_valid = 1'b1;
        do_reset();
        repeat (6) tick();
        chk("ar_in_issue", 64'(mem_valid), 64'd1);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("ar_mv_drop", 64'(mem_valid), 64'd0);
        chk("ar_busy_drop", 64'(busy), 64'd0);
        req1_addr  = 24'h000456;
        req1_valid = 1'b1;
        flash_en   = 1'b1;
        repeat (3) tick();
        chk("ar_no_ready", 64'(gq.size()), 64'd0);
        RST = 1'b1;
        wait_grants("ar_wait", 1, 20);
        chk("ar_first", 64'(gq.size() > 0 ? gq[0] : 9), 64'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
